// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and helpers for the register file slice
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ZERO     = 0;

  // Register index width; a single-register file still needs one address bit.
  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - writeback, read, issue and scoreboard signals of regfile_sb
interface regfile_sb_if
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32
);

  localparam int AW = calc_aw(NREGS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [XLEN:0] wr_data;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [XLEN:0] rs1_data;
  logic [XLEN:0] rs2_data;
  logic          issue_en;
  logic [AW-1:0] issue_rd;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          rd_busy;
  logic          hazard;
  logic [AW:0]   busy_count;

  modport master (
    output wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, issue_en, issue_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, rd_busy, hazard, busy_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, issue_en, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, rd_busy, hazard, busy_count
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits, busy counter and set/clear priority
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_rd,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rd_busy,
  output logic [AW:0]   busy_count
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             set_hit;
  logic             clr_hit;
  logic             inc;
  logic             dec;
  logic             rs1_fwd;
  logic             rs2_fwd;

  // Clear is applied before set so a new producer on the same index keeps it busy.
  always_comb begin
    set_hit  = issue_en && (issue_rd != AW'(REG_ZERO));
    clr_hit  = wr_en && (wr_addr != AW'(REG_ZERO));
    busy_nxt = busy;
    if (clr_hit) busy_nxt[wr_addr] = 1'b0;
    if (set_hit) busy_nxt[issue_rd] = 1'b1;
    inc = set_hit && !busy[issue_rd];
    dec = clr_hit && busy[wr_addr] && !(set_hit && (issue_rd == wr_addr));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= busy_count + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  end

  // A same-cycle writeback hides the busy bit only when its data is bypassed too.
  always_comb begin
    rs1_fwd  = BYPASS && wr_en && (wr_addr == rs1_addr);
    rs2_fwd  = BYPASS && wr_en && (wr_addr == rs2_addr);
    rs1_busy = busy[rs1_addr] && !rs1_fwd;
    rs2_busy = busy[rs2_addr] && !rs2_fwd;
    rd_busy  = busy[issue_rd];
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with x0 hardwired to zero, write bypass and busy scoreboard
module regfile_sb
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic        clk,
  input logic        resetn,
  regfile_sb_if.slave bus
);

  localparam int AW = calc_aw(NREGS);

  logic [XLEN:0] regs [NREGS];
  logic [XLEN:0] rs1_data;
  logic [XLEN:0] rs2_data;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          rd_busy;
  logic [AW:0]   busy_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wr_en && (bus.wr_addr != AW'(REG_ZERO))) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    rs1_data = regs[bus.rs1_addr];
    if (bus.rs1_addr == AW'(REG_ZERO))
      rs1_data = '0;
    else if (BYPASS && bus.wr_en && (bus.wr_addr == bus.rs1_addr))
      rs1_data = bus.wr_data;
  end

  always_comb begin
    rs2_data = regs[bus.rs2_addr];
    if (bus.rs2_addr == AW'(REG_ZERO))
      rs2_data = '0;
    else if (BYPASS && bus.wr_en && (bus.wr_addr == bus.rs2_addr))
      rs2_data = bus.wr_data;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .resetn     (resetn),
    .issue_en   (bus.issue_en),
    .issue_rd   (bus.issue_rd),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .rs1_addr   (bus.rs1_addr),
    .rs2_addr   (bus.rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rd_busy    (rd_busy),
    .busy_count (busy_count)
  );

  assign bus.rs1_data   = rs1_data;
  assign bus.rs2_data   = rs2_data;
  assign bus.rs1_busy   = rs1_busy;
  assign bus.rs2_busy   = rs2_busy;
  assign bus.rd_busy    = rd_busy;
  assign bus.hazard     = rs1_busy | rs2_busy | rd_busy;
  assign bus.busy_count = busy_count;

endmodule
